inst_fetch_unit: RTL and testbench

Instruction-fetch front end of the five-stage CPU. It owns the PC and issues word reads to the instruction memory interface with a request/valid handshake. It buffers returned instructions with their PCs in a small FIFO and presents them to decode under a valid/ready handshake. Branch/jump redirects from later stages flush it.

---
 rtl/inst_fetch_unit_if.sv | 31 +++
 rtl/inst_fetch_unit.sv | 107 ++++++++++
 tb/tb_inst_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_if
// Description : Instruction-memory and decode handshake bundle for the fetch
//               front end.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 7
);
    logic                       mem_request;
    logic [INST_ADDR_WIDTH-1:0] mem_addr;
    logic                       mem_valid;
    logic [INST_WIDTH-1:0]      mem_inst;
    logic                       id_valid;
    logic [INST_WIDTH-1:0]      id_inst;
    logic [INST_ADDR_WIDTH-1:0] id_pc;
    logic                       id_ready;

    // master = fetch unit, slave = memory/decode side
    modport master (
        output mem_request, mem_addr, id_valid, id_inst, id_pc,
        input  mem_valid, mem_inst, id_ready
    );
    modport slave (
        input  mem_request, mem_addr, id_valid, id_inst, id_pc,
        output mem_valid, mem_inst, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : PC owner, single-outstanding instruction fetch and small
//               fetch buffer feeding decode; flushed by redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int                         INST_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 7,
    parameter int                         FIFO_DEPTH      = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       start,
    input  wire logic                       redirect_valid,
    input  wire logic [INST_ADDR_WIDTH-1:0] redirect_addr,
    inst_fetch_unit_if.master               bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t                     r_state;
    logic [INST_ADDR_WIDTH-1:0] r_pc;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;
    logic [INST_WIDTH-1:0]      r_inst_mem [FIFO_DEPTH];
    logic [INST_ADDR_WIDTH-1:0] r_pc_mem   [FIFO_DEPTH];

    logic w_full;
    logic w_req;
    logic w_push;
    logic w_pop;
    logic w_id_valid;

    assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_id_valid = (r_count != '0);
    assign w_req      = (r_state == S_REQ) && !w_full && !redirect_valid;
    assign w_push     = (r_state == S_WAIT) && bus.mem_valid && !redirect_valid;
    assign w_pop      = w_id_valid && bus.id_ready;

    assign bus.mem_request = w_req;
    assign bus.mem_addr    = r_pc;
    assign bus.id_valid    = w_id_valid;
    assign bus.id_inst     = w_id_valid ? r_inst_mem[r_rd_ptr] : '0;
    assign bus.id_pc       = w_id_valid ? r_pc_mem[r_rd_ptr]   : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            // Redirect beats push and pop; an outstanding response is either
            // dropped now or must be waited out in FLUSH.
            r_pc     <= redirect_addr;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            case (r_state)
                S_WAIT:  r_state <= bus.mem_valid ? S_REQ : S_FLUSH;
                S_FLUSH: if (bus.mem_valid) r_state <= S_REQ;
                default: r_state <= r_state;
            endcase
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_REQ;
                S_REQ:   if (!w_full) r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.mem_valid) begin
                        r_pc    <= r_pc + INST_ADDR_WIDTH'(1);
                        r_state <= S_REQ;
                    end
                end
                S_FLUSH: if (bus.mem_valid) r_state <= S_REQ;
                default: r_state <= S_IDLE;
            endcase
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by the entry count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= bus.mem_inst;
            r_pc_mem[r_wr_ptr]   <= r_pc;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Randomised and directed bench for inst_fetch_unit against a
//               transaction-level fetch model and a latency-L memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;
    localparam int c_DEPTH = 4;

    typedef struct {
        logic [6:0]  pc;
        logic [31:0] inst;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       redirect_valid;
    logic [6:0] redirect_addr;

    inst_fetch_unit_if #(.INST_WIDTH(32), .INST_ADDR_WIDTH(7)) bus ();

    inst_fetch_unit #(
        .INST_WIDTH(32), .INST_ADDR_WIDTH(7), .FIFO_DEPTH(c_DEPTH), .RESET_PC(7'd0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat    = 2;

    // memory: one pending response slot
    logic       pend = 1'b0;
    logic [6:0] pend_addr;
    int         pend_due;

    // fetch model
    logic       m_known  = 1'b0;
    logic       m_active;
    logic       m_out;
    logic       m_stale;
    logic [6:0] m_pc;
    ent_t       m_q[$];

    ent_t       pop_log[$];
    int         pop_cyc[$];
    logic [6:0] req_log[$];
    int         req_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        return 32'h100 + 32'(a);
    endfunction

    // Runs at the falling edge: compare, log, then advance the model by one cycle.
    task automatic step();
        logic        e_req;
        logic        e_pop;
        logic [31:0] e_inst;
        logic [6:0]  e_pc;
        e_req  = m_active && !m_out && (m_q.size() < c_DEPTH) && !redirect_valid;
        e_inst = (m_q.size() > 0) ? m_q[0].inst : 32'h0;
        e_pc   = (m_q.size() > 0) ? m_q[0].pc   : 7'h0;
        if (m_known) begin
            chk("mem_request", 64'(bus.mem_request), 64'(e_req));
            chk("mem_addr",    64'(bus.mem_addr),    64'(m_pc));
            chk("id_valid",    64'(bus.id_valid),    64'(m_q.size() > 0));
            chk("id_inst",     64'(bus.id_inst),     64'(e_inst));
            chk("id_pc",       64'(bus.id_pc),       64'(e_pc));
        end
        if (bus.mem_request === 1'b1) begin
            pend = 1'b1; pend_addr = bus.mem_addr; pend_due = cyc + lat;
            req_log.push_back(bus.mem_addr); req_cyc.push_back(cyc);
        end
        if (rst_n && bus.id_valid === 1'b1 && bus.id_ready) begin
            pop_log.push_back('{bus.id_pc, bus.id_inst}); pop_cyc.push_back(cyc);
        end

        e_pop = (m_q.size() > 0) && bus.id_ready;
        if (!rst_n) begin
            m_known = 1'b1; m_active = 1'b0; m_out = 1'b0; m_stale = 1'b0;
            m_pc = 7'd0; m_q.delete();
        end else if (redirect_valid) begin
            m_pc = redirect_addr;
            m_q.delete();
            if (m_out && bus.mem_valid) begin
                m_out = 1'b0; m_stale = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_out && bus.mem_valid) begin
                if (!m_stale) begin
                    m_q.push_back('{m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 7'd1;
                end
                m_out = 1'b0; m_stale = 1'b0;
            end
            if (e_req) m_out = 1'b1;
            if (!m_active && start) m_active = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend && cyc == pend_due) begin
            bus.mem_valid = 1'b1; bus.mem_inst = mem_word(pend_addr); pend = 1'b0;
        end else begin
            bus.mem_valid = 1'b0; bus.mem_inst = $urandom;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_logs();
        pop_log.delete(); pop_cyc.delete(); req_log.delete(); req_cyc.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0;
        run(4);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic chk_pop(input string name, input int idx, input logic [6:0] pc,
                           input logic [31:0] inst);
        if (pop_log.size() > idx) begin
            chk({name, "_pc"},   64'(pop_log[idx].pc),   64'(pc));
            chk({name, "_inst"}, 64'(pop_log[idx].inst), 64'(inst));
        end else begin
            chk({name, "_count"}, 64'(pop_log.size()), 64'(idx + 1));
        end
    endtask

    task automatic chk_req(input string name, input int idx, input logic [6:0] addr);
        if (req_log.size() > idx) chk(name, 64'(req_log[idx]), 64'(addr));
        else                      chk({name, "_count"}, 64'(req_log.size()), 64'(idx + 1));
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_addr = 7'd0;
        bus.mem_valid = 1'b0; bus.mem_inst = '0; bus.id_ready = 1'b1;

        // reset values
        reset_dut();
        chk("rst_mem_request", 64'(bus.mem_request), 64'(0));
        chk("rst_mem_addr",    64'(bus.mem_addr),    64'(0));
        chk("rst_id_valid",    64'(bus.id_valid),    64'(0));

        // streaming with L=2
        lat = 2; bus.id_ready = 1'b1;
        clear_logs(); pulse_start(); run(20);
        chk_req("t1_req0", 0, 7'd0); chk_req("t1_req1", 1, 7'd1); chk_req("t1_req2", 2, 7'd2);
        if (req_cyc.size() >= 2) chk("t1_spacing", 64'(req_cyc[1] - req_cyc[0]), 64'(3));
        chk_pop("t1_pop0", 0, 7'd0, 32'h100);
        chk_pop("t1_pop1", 1, 7'd1, 32'h101);
        chk_pop("t1_pop2", 2, 7'd2, 32'h102);

        // decode stalled: buffer fills, fetch stops, then drains
        reset_dut(); bus.id_ready = 1'b0;
        clear_logs(); pulse_start(); run(40);
        chk("t2_req_count", 64'(req_log.size()), 64'(4));
        clear_logs(); bus.id_ready = 1'b1; run(12);
        for (int i = 0; i < 4; i++) chk_pop("t2_drain", i, 7'(i), 32'h100 + 32'(i));
        if (pop_cyc.size() >= 4) chk("t2_back_to_back", 64'(pop_cyc[3] - pop_cyc[0]), 64'(3));
        chk_req("t2_resume", 0, 7'd4);

        // redirect while waiting on addr 5
        reset_dut(); bus.id_ready = 1'b1;
        clear_logs(); pulse_start();
        guard = 0;
        while (!(req_log.size() > 0 && req_log[$] == 7'd5) && guard < 100) begin
            tick(); guard++;
        end
        chk("t3_reached_addr5", 64'(guard < 100), 64'(1));
        clear_logs();
        redirect_valid = 1'b1; redirect_addr = 7'h40; tick(); redirect_valid = 1'b0;
        pop_log.delete(); run(15);
        chk_req("t3_req_after", 0, 7'h40);
        chk_pop("t3_first_pop", 0, 7'h40, 32'h140);

        // redirect coincident with a response while 2 entries are buffered
        reset_dut(); bus.id_ready = 1'b0;
        clear_logs(); pulse_start();
        guard = 0;
        while (!(bus.mem_valid && m_q.size() == 2) && guard < 100) begin
            tick(); guard++;
        end
        chk("t4_reached", 64'(guard < 100), 64'(1));
        redirect_valid = 1'b1; redirect_addr = 7'h20; tick(); redirect_valid = 1'b0;
        chk("t4_flushed", 64'(bus.id_valid), 64'(0));
        clear_logs(); bus.id_ready = 1'b1; run(12);
        chk_req("t4_req_after", 0, 7'h20);
        chk_pop("t4_first_pop", 0, 7'h20, 32'h120);

        // PC wrap
        redirect_valid = 1'b1; redirect_addr = 7'h7F; tick(); redirect_valid = 1'b0;
        clear_logs(); run(20);
        chk_pop("t5_pop0", 0, 7'h7F, 32'h17F);
        chk_pop("t5_pop1", 1, 7'h00, 32'h100);

        // reset in WAIT with 3 entries; late response must be ignored
        reset_dut(); bus.id_ready = 1'b0;
        clear_logs(); pulse_start();
        guard = 0;
        while (!(m_out && m_q.size() == 3) && guard < 100) begin
            tick(); guard++;
        end
        chk("t6_reached", 64'(guard < 100), 64'(1));
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6_id_valid", 64'(bus.id_valid),    64'(0));
        chk("t6_id_inst",  64'(bus.id_inst),     64'(0));
        chk("t6_id_pc",    64'(bus.id_pc),       64'(0));
        chk("t6_request",  64'(bus.mem_request), 64'(0));
        chk("t6_addr",     64'(bus.mem_addr),    64'(0));
        run(5);
        chk("t6_still_empty", 64'(bus.id_valid), 64'(0));
        clear_logs(); pulse_start(); run(6);
        chk_req("t6_restart", 0, 7'd0);

        // randomised traffic
        for (int seg = 0; seg < 8; seg++) begin
            lat = int'($urandom_range(1, 3));
            if (seg == 4) begin
                reset_dut(); pulse_start();
            end
            for (int i = 0; i < 250; i++) begin
                bus.id_ready   = ($urandom % 4) != 0;
                redirect_valid = ($urandom % 16) == 0;
                redirect_addr  = (($urandom % 8) == 0) ? 7'(7'h7E + 7'($urandom % 2)) : 7'($urandom);
                start          = ($urandom % 8) == 0;
                tick();
            end
            redirect_valid = 1'b0; start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
